regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning entry count (power of 2, >=2); AW = log2(DEPTH).
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2, meaning number of write ports (1..2).
REQ-005 SHALL have parameter ZERO_R0, default 1, meaning entry 0 reads as zero and ignores writes.
REQ-006 SHALL have port clk  input  1  the single clock; all logic on the rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-008 SHALL have port stall  input  1  freeze: no writes commit, read outputs hold, sweep pauses.
REQ-009 SHALL have port clr_req  input  1  single-cycle request to zero all entries.
REQ-010 SHALL have port clr_busy  output  1  high while the clear sweep runs.
REQ-011 SHALL have port clr_done  output  1  one-cycle pulse when the sweep completes.
REQ-012 SHALL have port wr_en  input  NWR  per-port write enable.
REQ-013 SHALL have port wr_addr  input  NWR x AW  per-port write index.
REQ-014 SHALL have port wr_data  input  NWR x DATA_W  per-port write data.
REQ-015 SHALL have port rd_addr  input  NRD x AW  per-port read index.
REQ-016 SHALL have port rd_data  output  NRD x DATA_W  registered per-port read data.

Function
REQ-017 SHALL commit wr_data[p] to entry wr_addr[p] at the clock edge when wr_en[p]=1, stall=0, FSM in IDLE, and not (ZERO_R0=1 and wr_addr[p]=0).
REQ-018 SHALL, when two enabled write ports target the same entry in one cycle, commit the higher-index port only.
REQ-019 SHALL register read data with 1-cycle latency: rd_data[r] at edge N+1 reflects rd_addr[r] sampled at edge N.
REQ-020 SHALL bypass: if a committing write targets rd_addr[r] in the same cycle, rd_data[r] takes that write data (higher-index port wins), else the stored entry.
REQ-021 SHALL return 0 on rd_data[r] for rd_addr[r]=0 when ZERO_R0=1, regardless of writes.
REQ-022 SHALL hold all rd_data and the stored array unchanged while stall=1.
REQ-023 SHALL implement FSM IDLE -> SWEEP -> DONE -> IDLE; IDLE->SWEEP on clr_req=1 with stall=0.
REQ-024 SHALL in SWEEP zero one entry per unstalled cycle using a counter 0..DEPTH-1; after entry DEPTH-1 go to DONE.
REQ-025 SHALL drive clr_busy=1 in SWEEP and DONE; clr_done=1 only in DONE (one cycle, then IDLE).
REQ-026 SHALL ignore all writes and force rd_data to 0 while clr_busy=1.
REQ-027 SHALL ignore clr_req while clr_busy=1 (no restart, no queueing).
REQ-028 SHALL complete a clear in exactly DEPTH+1 unstalled cycles from the clr_req edge to the clr_done pulse.

Reset
REQ-029 SHALL, when rst=0 at a clock edge, zero every entry, every rd_data, the sweep counter, and return FSM to IDLE (clr_busy=0, clr_done=0).
REQ-030 SHALL give reset priority over stall, clr_req and writes, including mid-sweep.

Structure
REQ-031 SHALL place the FSM state enum and default parameter constants in shared package regfile_pkg.
REQ-032 SHALL instantiate sub-module regfile_rdport once per read port, containing the bypass priority mux and the rd_data register.

Verification
REQ-033 SHALL cover: write p0 addr 5 = 0xDEADBEEF, next cycle read addr 5 -> rd_data[0]=0xDEADBEEF one cycle later.
REQ-034 SHALL cover: same cycle wr p0 addr 7=0x11, wr p1 addr 7=0x22, rd addr 7 -> rd_data=0x22 (bypass) and later reads 0x22.
REQ-035 SHALL cover: write addr 0 = 0xFFFF_FFFF with ZERO_R0=1 -> read addr 0 returns 0.
REQ-036 SHALL cover: stall=1 for 3 cycles with wr_en=1 addr 3=0x55 -> entry 3 unchanged, rd_data held all 3 cycles.
REQ-037 SHALL cover: fill all 32 entries, clr_req pulse -> clr_busy high 33 cycles, clr_done at cycle 33, all reads 0; writes during sweep lost.
REQ-038 SHALL cover: rst=0 at sweep counter 10 -> next cycle IDLE, clr_busy=0, all entries 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type and default parameters for the multi-port register file
package regfile_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  localparam int DATA_W_DEF  = 32;
  localparam int DEPTH_DEF   = 32;
  localparam int NRD_DEF     = 2;
  localparam int NWR_DEF     = 2;
  localparam bit ZERO_R0_DEF = 1'b1;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write/read/clear bus of the multi-port register file
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NWR    = NWR_DEF
);
  localparam int AW = $clog2(DEPTH);
  logic                         stall;
  logic                         clr_req;
  logic                         clr_busy;
  logic                         clr_done;
  logic [NWR-1:0]               wr_en;
  logic [NWR-1:0][AW-1:0]       wr_addr;
  logic [NWR-1:0][DATA_W-1:0]   wr_data;
  logic [NRD-1:0][AW-1:0]       rd_addr;
  logic [NRD-1:0][DATA_W-1:0]   rd_data;
  modport master (
    output stall, clr_req, wr_en, wr_addr, wr_data, rd_addr,
    input  clr_busy, clr_done, rd_data
  );
  modport slave (
    input  stall, clr_req, wr_en, wr_addr, wr_data, rd_addr,
    output clr_busy, clr_done, rd_data
  );
endinterface

// File: rtl/regfile_rdport.sv
// regfile_rdport: one registered read port with write-bypass priority mux
module regfile_rdport import regfile_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int AW      = $clog2(DEPTH_DEF),
  parameter int NWR     = NWR_DEF,
  parameter bit ZERO_R0 = ZERO_R0_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       clr,
  input  logic [AW-1:0]              rd_addr,
  input  logic [DATA_W-1:0]          stored,
  input  logic [NWR-1:0]             wr_commit,
  input  logic [NWR-1:0][AW-1:0]     wr_addr,
  input  logic [NWR-1:0][DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]          rd_data
);
  logic [DATA_W-1:0] rd_n;
  // later ports overwrite earlier ones, so the highest committing port wins
  always_comb begin
    rd_n = stored;
    for (int p = 0; p < NWR; p++) rd_n = (wr_commit[p] && wr_addr[p] == rd_addr) ? wr_data[p] : rd_n;
    rd_n = (clr || (ZERO_R0 && rd_addr == '0)) ? '0 : rd_n;
  end
  always_ff @(posedge clk) begin
    if (!rst) rd_data <= '0;
    else if (!stall) rd_data <= rd_n;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with bypassed registered reads and a clear sweep
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int NRD     = NRD_DEF,
  parameter int NWR     = NWR_DEF,
  parameter bit ZERO_R0 = ZERO_R0_DEF
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  state_t            state_q, state_n;
  logic [AW-1:0]     cnt_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [NWR-1:0]    wr_commit;
  logic              busy_n;
  always_comb begin
    state_n = state_q;
    if (!bus.stall)
      state_n = state_q == IDLE  ? (bus.clr_req ? SWEEP : IDLE) :
                state_q == SWEEP ? (cnt_q == AW'(DEPTH - 1) ? DONE : SWEEP) : IDLE;
    busy_n = state_n != IDLE;
  end
  assign bus.clr_busy = state_q != IDLE;
  assign bus.clr_done = state_q == DONE;
  always_comb begin
    wr_commit = '0;
    for (int p = 0; p < NWR; p++)
      wr_commit[p] = bus.wr_en[p] && !bus.stall && state_q == IDLE && !(ZERO_R0 && bus.wr_addr[p] == '0);
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? state_n : IDLE;
  end
  // the sweep counter wraps back to 0 on its last entry, ready for the next clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (state_q == SWEEP && !bus.stall) begin
        mem[cnt_q] <= '0;
        cnt_q      <= cnt_q + 1'b1;
      end
      for (int p = 0; p < NWR; p++) if (wr_commit[p]) mem[bus.wr_addr[p]] <= bus.wr_data[p];
    end
  end
  for (genvar r = 0; r < NRD; r++) begin : g_rd
    regfile_rdport #(.DATA_W(DATA_W), .AW(AW), .NWR(NWR), .ZERO_R0(ZERO_R0)) u_rd (
      .clk       (clk),
      .rst       (rst),
      .stall     (bus.stall),
      .clr       (busy_n),
      .rd_addr   (bus.rd_addr[r]),
      .stored    (mem[bus.rd_addr[r]]),
      .wr_commit (wr_commit),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
      .rd_data   (bus.rd_data[r])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp covering bypass, stall, zero entry and clear sweep
module tb_regfile_mp;
  import regfile_pkg::*;
  localparam int DW = DATA_W_DEF, DEPTH = 32, NRD = 2, NWR = 2, AW = 5;
  typedef struct {int port; logic [DW-1:0] val; string tag;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0, errors = 0;
  exp_t sb[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last [NRD];
  regfile_mp_if #(.DATA_W(DW), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR)) bus ();
  regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR), .ZERO_R0(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.stall = 1'b0; bus.clr_req = 1'b0; bus.wr_en = '0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
  endtask
  task automatic push(int port, logic [DW-1:0] val, string tag);
    sb.push_back('{port, val, tag});
    last[port] = val;
  endtask
  task automatic wr(int p, int addr, logic [DW-1:0] data);
    bus.wr_en[p] = 1'b1; bus.wr_addr[p] = AW'(addr); bus.wr_data[p] = data;
  endtask
  task automatic test_reset();
    exp_t e;
    idle(); rst = 1'b0;
    cyc(); cyc();
    checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.clr_busy); end
    checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus.clr_done); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL rst_rd got %h want 0", bus.rd_data); end
    rst = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      model[a] = '0;
      bus.rd_addr[0] = AW'(a); bus.rd_addr[1] = AW'(DEPTH - 1 - a);
      push(0, '0, "rst_entry"); push(1, '0, "rst_entry");
      cyc();
      while (sb.size() > 0) begin e = sb.pop_front(); checks++;
        if (bus.rd_data[e.port] !== e.val) begin errors++; $display("FAIL %s rd_data[%0d] got %h want %h", e.tag, e.port, bus.rd_data[e.port], e.val); end
      end
    end
  endtask
  task automatic test_random();
    exp_t e;
    logic [DW-1:0] v;
    for (int n = 0; n < 120; n++) begin
      bus.stall = ($urandom_range(0, 4) == 0);
      for (int p = 0; p < NWR; p++) begin
        bus.wr_en[p] = 1'($urandom_range(0, 1)); bus.wr_addr[p] = AW'($urandom_range(0, 7)); bus.wr_data[p] = $urandom;
      end
      for (int r = 0; r < NRD; r++) begin
        bus.rd_addr[r] = AW'($urandom_range(0, 7));
        if (bus.stall) v = last[r];
        else if (bus.rd_addr[r] == '0) v = '0;
        else begin
          v = model[bus.rd_addr[r]];
          for (int p = 0; p < NWR; p++) if (bus.wr_en[p] && bus.wr_addr[p] == bus.rd_addr[r]) v = bus.wr_data[p];
        end
        push(r, v, "random");
      end
      if (!bus.stall)
        for (int p = 0; p < NWR; p++) if (bus.wr_en[p] && bus.wr_addr[p] != '0) model[bus.wr_addr[p]] = bus.wr_data[p];
      cyc();
      while (sb.size() > 0) begin e = sb.pop_front(); checks++;
        if (bus.rd_data[e.port] !== e.val) begin errors++; $display("FAIL %s rd_data[%0d] got %h want %h", e.tag, e.port, bus.rd_data[e.port], e.val); end
      end
    end
    idle();
  endtask
  task automatic test_write_read();
    exp_t e;
    idle(); wr(0, 5, 32'hDEAD_BEEF); bus.rd_addr[1] = AW'(9); push(1, model[9], "wr5_other");
    model[5] = 32'hDEAD_BEEF;
    cyc();
    idle(); bus.rd_addr[0] = AW'(5); push(0, 32'hDEAD_BEEF, "rd5");
    cyc();
    while (sb.size() > 0) begin e = sb.pop_front(); checks++;
      if (bus.rd_data[e.port] !== e.val) begin errors++; $display("FAIL %s rd_data[%0d] got %h want %h", e.tag, e.port, bus.rd_data[e.port], e.val); end
    end
  endtask
  task automatic test_same_addr();
    exp_t e;
    idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22);
    bus.rd_addr[0] = AW'(7); bus.rd_addr[1] = AW'(7);
    push(0, 32'h22, "wr7_bypass"); push(1, 32'h22, "wr7_bypass");
    model[7] = 32'h22;
    cyc();
    bus.wr_en = '0; push(0, 32'h22, "wr7_stored"); push(1, 32'h22, "wr7_stored");
    cyc();
    while (sb.size() > 0) begin e = sb.pop_front(); checks++;
      if (bus.rd_data[e.port] !== e.val) begin errors++; $display("FAIL %s rd_data[%0d] got %h want %h", e.tag, e.port, bus.rd_data[e.port], e.val); end
    end
  endtask
  task automatic test_zero_r0();
    exp_t e;
    idle(); wr(0, 0, 32'hFFFF_FFFF); wr(1, 0, 32'hFFFF_FFFF);
    push(0, '0, "r0_bypass"); push(1, '0, "r0_bypass");
    cyc();
    while (sb.size() > 0) begin e = sb.pop_front(); checks++;
      if (bus.rd_data[e.port] !== e.val) begin errors++; $display("FAIL %s rd_data[%0d] got %h want %h", e.tag, e.port, bus.rd_data[e.port], e.val); end
    end
    bus.wr_en = '0; push(0, '0, "r0_stored"); push(1, '0, "r0_stored");
    cyc();
    while (sb.size() > 0) begin e = sb.pop_front(); checks++;
      if (bus.rd_data[e.port] !== e.val) begin errors++; $display("FAIL %s rd_data[%0d] got %h want %h", e.tag, e.port, bus.rd_data[e.port], e.val); end
    end
  endtask
  task automatic test_stall();
    exp_t e;
    idle(); wr(0, 3, 32'h1234_5678); bus.rd_addr[0] = AW'(5); bus.rd_addr[1] = AW'(3);
    push(0, 32'hDEAD_BEEF, "stall_pre"); push(1, 32'h1234_5678, "stall_pre");
    model[3] = 32'h1234_5678;
    cyc();
    for (int n = 0; n < 3; n++) begin
      bus.stall = 1'b1; wr(0, 3, 32'h55); bus.rd_addr[0] = AW'(7); bus.rd_addr[1] = AW'(3);
      push(0, 32'hDEAD_BEEF, "stall_hold"); push(1, 32'h1234_5678, "stall_hold");
      cyc();
      while (sb.size() > 0) begin e = sb.pop_front(); checks++;
        if (bus.rd_data[e.port] !== e.val) begin errors++; $display("FAIL %s rd_data[%0d] got %h want %h", e.tag, e.port, bus.rd_data[e.port], e.val); end
      end
    end
    bus.stall = 1'b0; bus.wr_en = '0;
    push(0, 32'h22, "stall_post"); push(1, 32'h1234_5678, "stall_post");
    cyc();
    while (sb.size() > 0) begin e = sb.pop_front(); checks++;
      if (bus.rd_data[e.port] !== e.val) begin errors++; $display("FAIL %s rd_data[%0d] got %h want %h", e.tag, e.port, bus.rd_data[e.port], e.val); end
    end
  endtask
  task automatic test_clear();
    exp_t e;
    idle();
    for (int i = 0; i < DEPTH / 2; i++) begin
      wr(0, 2 * i, 32'hA000_0000 + 32'(2 * i)); wr(1, 2 * i + 1, 32'hA000_0000 + 32'(2 * i + 1));
      if (i != 0) model[2 * i] = 32'hA000_0000 + 32'(2 * i);
      model[2 * i + 1] = 32'hA000_0000 + 32'(2 * i + 1);
      cyc();
    end
    idle(); bus.rd_addr[0] = AW'(31); bus.rd_addr[1] = AW'(1);
    push(0, model[31], "fill"); push(1, model[1], "fill");
    cyc();
    while (sb.size() > 0) begin e = sb.pop_front(); checks++;
      if (bus.rd_data[e.port] !== e.val) begin errors++; $display("FAIL %s rd_data[%0d] got %h want %h", e.tag, e.port, bus.rd_data[e.port], e.val); end
    end
    bus.clr_req = 1'b1;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      push(0, '0, "sweep_rd"); push(1, '0, "sweep_rd");
      cyc();
      while (sb.size() > 0) begin e = sb.pop_front(); checks++;
        if (bus.rd_data[e.port] !== e.val) begin errors++; $display("FAIL %s rd_data[%0d] got %h want %h", e.tag, e.port, bus.rd_data[e.port], e.val); end
      end
      checks++; if (bus.clr_busy !== 1'b1) begin errors++; $display("FAIL sweep_busy cycle %0d got %b want 1", k, bus.clr_busy); end
      checks++; if (bus.clr_done !== 1'(k == DEPTH + 1)) begin errors++; $display("FAIL sweep_done cycle %0d got %b want %b", k, bus.clr_done, k == DEPTH + 1); end
      bus.clr_req = (k % 7 == 0);
      for (int p = 0; p < NWR; p++) begin
        bus.wr_en[p] = (k < DEPTH + 1); bus.wr_addr[p] = AW'($urandom_range(1, DEPTH - 1)); bus.wr_data[p] = $urandom;
      end
    end
    idle(); push(0, '0, "sweep_end"); push(1, '0, "sweep_end");
    cyc();
    checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL sweep_end_busy got %b want 0", bus.clr_busy); end
    checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL sweep_end_done got %b want 0", bus.clr_done); end
    for (int a = 0; a < DEPTH; a++) begin
      model[a] = '0;
      bus.rd_addr[0] = AW'(a); bus.rd_addr[1] = AW'(DEPTH - 1 - a);
      push(0, '0, "cleared"); push(1, '0, "cleared");
      cyc();
      while (sb.size() > 0) begin e = sb.pop_front(); checks++;
        if (bus.rd_data[e.port] !== e.val) begin errors++; $display("FAIL %s rd_data[%0d] got %h want %h", e.tag, e.port, bus.rd_data[e.port], e.val); end
      end
    end
  endtask
  task automatic test_reset_mid_sweep();
    exp_t e;
    idle(); wr(0, 20, 32'h77); wr(1, 25, 32'h99);
    cyc();
    idle(); bus.clr_req = 1'b1;
    cyc();
    bus.clr_req = 1'b0;
    repeat (10) cyc();
    checks++; if (bus.clr_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", bus.clr_busy); end
    rst = 1'b0; bus.stall = 1'b1; bus.clr_req = 1'b1; wr(0, 20, 32'h5A);
    cyc();
    checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", bus.clr_busy); end
    checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b want 0", bus.clr_done); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL mid_rst_rd got %h want 0", bus.rd_data); end
    idle(); rst = 1'b1;
    bus.rd_addr[0] = AW'(20); bus.rd_addr[1] = AW'(25);
    push(0, '0, "mid_rst_entry"); push(1, '0, "mid_rst_entry");
    cyc();
    while (sb.size() > 0) begin e = sb.pop_front(); checks++;
      if (bus.rd_data[e.port] !== e.val) begin errors++; $display("FAIL %s rd_data[%0d] got %h want %h", e.tag, e.port, bus.rd_data[e.port], e.val); end
    end
  endtask
  initial begin
    idle();
    test_reset();
    test_random();
    test_write_read();
    test_same_addr();
    test_zero_r0();
    test_stall();
    test_clear();
    test_reset_mid_sweep();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
